// File: rtl/activation_cache.sv
// activation_cache
//   Causal dilated tap cache. Keeps the last 3*DILATION+1 eight-channel
//   activation vectors in a circular buffer. For every accepted vector it
//   presents four taps at ages 3*DILATION, 2*DILATION, DILATION and 0 on
//   a0..a3, with a one-cycle out_v pulse. Taps reaching past the recorded
//   history read as zero (causal zero padding).
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   inp_v/inp_ready  input handshake, one vector per 3 cycles
//   inp_d0..inp_d7   signed input channels (W bits, passed bit-exact)
//   a0_d*..a3_d*     taps, oldest (a0) to current (a3); hold between pulses
//   out_v            one-cycle pulse when all taps update
module activation_cache #(
  parameter int W        = 16,
  parameter int DILATION = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inp_v,
  output logic         inp_ready,
  input  logic [W-1:0] inp_d0, inp_d1, inp_d2, inp_d3,
  input  logic [W-1:0] inp_d4, inp_d5, inp_d6, inp_d7,
  output logic [W-1:0] a0_d0, a0_d1, a0_d2, a0_d3, a0_d4, a0_d5, a0_d6, a0_d7,
  output logic [W-1:0] a1_d0, a1_d1, a1_d2, a1_d3, a1_d4, a1_d5, a1_d6, a1_d7,
  output logic [W-1:0] a2_d0, a2_d1, a2_d2, a2_d3, a2_d4, a2_d5, a2_d6, a2_d7,
  output logic [W-1:0] a3_d0, a3_d1, a3_d2, a3_d3, a3_d4, a3_d5, a3_d6, a3_d7,
  output logic         out_v
);
  localparam int DEPTH = 3*DILATION + 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [7:0][W-1:0] vec_t;
  typedef enum logic [1:0] {IDLE, READ, EMIT} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     fill_q, fill_d;
  logic [2:0][PW-1:0] idx_q, idx_d;
  logic [2:0][PW-1:0] off;
  vec_t              hold_q, hold_d;
  vec_t [2:0]        rd_q, rd_d;
  vec_t [3:0]        tap_q, tap_d;
  logic              out_v_q, out_v_d;
  vec_t              mem [DEPTH];
  vec_t              inp_vec;

  assign inp_vec   = {inp_d7, inp_d6, inp_d5, inp_d4, inp_d3, inp_d2, inp_d1, inp_d0};
  assign inp_ready = (state_q == IDLE);
  assign out_v     = out_v_q;

  // Age of tap k in samples; also the history needed before tap k is real.
  for (genvar g = 0; g < 3; g++) begin : g_off
    assign off[g] = PW'((3 - g) * DILATION);
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    rd_d     = rd_q;
    tap_d    = tap_q;
    out_v_d  = 1'b0;
    case (state_q)
      IDLE: if (inp_v) begin
        hold_d = inp_vec;
        // Modulo DEPTH without division: wrap by adding DEPTH on underflow.
        // The add may overflow PW bits, but the true result is < DEPTH so the
        // truncated sum is still exact.
        for (int k = 0; k < 3; k++)
          idx_d[k] = (wr_ptr_q >= off[k]) ? wr_ptr_q - off[k]
                                          : wr_ptr_q + PW'(DEPTH) - off[k];
        state_d = READ;
      end
      READ: begin
        for (int k = 0; k < 3; k++)
          rd_d[k] = (fill_q < off[k]) ? '0 : mem[idx_q[k]];
        state_d = EMIT;
      end
      EMIT: begin
        // a3 comes from the holding register, never from memory.
        tap_d    = {hold_q, rd_q[2], rd_q[1], rd_q[0]};
        out_v_d  = 1'b1;
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        fill_d   = (fill_q == off[0]) ? fill_q : fill_q + PW'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      idx_q    <= '0;
      hold_q   <= '0;
      rd_q     <= '0;
      tap_q    <= '0;
      out_v_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      rd_q     <= rd_d;
      tap_q    <= tap_d;
      out_v_q  <= out_v_d;
    end
  end

  // Storage is never cleared; stale slots are masked by fill.
  always_ff @(posedge clk) begin
    if (!rst && inp_ready && inp_v) mem[wr_ptr_q] <= inp_vec;
  end

  assign a0_d0 = tap_q[0][0]; assign a0_d1 = tap_q[0][1]; assign a0_d2 = tap_q[0][2]; assign a0_d3 = tap_q[0][3];
  assign a0_d4 = tap_q[0][4]; assign a0_d5 = tap_q[0][5]; assign a0_d6 = tap_q[0][6]; assign a0_d7 = tap_q[0][7];
  assign a1_d0 = tap_q[1][0]; assign a1_d1 = tap_q[1][1]; assign a1_d2 = tap_q[1][2]; assign a1_d3 = tap_q[1][3];
  assign a1_d4 = tap_q[1][4]; assign a1_d5 = tap_q[1][5]; assign a1_d6 = tap_q[1][6]; assign a1_d7 = tap_q[1][7];
  assign a2_d0 = tap_q[2][0]; assign a2_d1 = tap_q[2][1]; assign a2_d2 = tap_q[2][2]; assign a2_d3 = tap_q[2][3];
  assign a2_d4 = tap_q[2][4]; assign a2_d5 = tap_q[2][5]; assign a2_d6 = tap_q[2][6]; assign a2_d7 = tap_q[2][7];
  assign a3_d0 = tap_q[3][0]; assign a3_d1 = tap_q[3][1]; assign a3_d2 = tap_q[3][2]; assign a3_d3 = tap_q[3][3];
  assign a3_d4 = tap_q[3][4]; assign a3_d5 = tap_q[3][5]; assign a3_d6 = tap_q[3][6]; assign a3_d7 = tap_q[3][7];
endmodule

// File: tb/tb_activation_cache.sv
module tb_activation_cache;
  localparam int W = 16;
  typedef logic [7:0][W-1:0] vec_t;
  typedef struct {
    logic [W-1:0]        in;
    logic [3:0][W-1:0]   e;   // expected a0..a3 (DILATION 1), same on all channels
  } row_t;

  logic clk = 1'b0;
  logic rst, inp_v;
  vec_t inp;
  logic rdy1, rdy4, ov1, ov4;
  logic [3:0][7:0][W-1:0] t1, t4;
  vec_t hist[$];   // accepted vectors since the last reset, oldest first
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  activation_cache #(.W(W), .DILATION(1)) u1 (
    .clk(clk), .rst(rst), .inp_v(inp_v), .inp_ready(rdy1),
    .inp_d0(inp[0]), .inp_d1(inp[1]), .inp_d2(inp[2]), .inp_d3(inp[3]),
    .inp_d4(inp[4]), .inp_d5(inp[5]), .inp_d6(inp[6]), .inp_d7(inp[7]),
    .a0_d0(t1[0][0]), .a0_d1(t1[0][1]), .a0_d2(t1[0][2]), .a0_d3(t1[0][3]),
    .a0_d4(t1[0][4]), .a0_d5(t1[0][5]), .a0_d6(t1[0][6]), .a0_d7(t1[0][7]),
    .a1_d0(t1[1][0]), .a1_d1(t1[1][1]), .a1_d2(t1[1][2]), .a1_d3(t1[1][3]),
    .a1_d4(t1[1][4]), .a1_d5(t1[1][5]), .a1_d6(t1[1][6]), .a1_d7(t1[1][7]),
    .a2_d0(t1[2][0]), .a2_d1(t1[2][1]), .a2_d2(t1[2][2]), .a2_d3(t1[2][3]),
    .a2_d4(t1[2][4]), .a2_d5(t1[2][5]), .a2_d6(t1[2][6]), .a2_d7(t1[2][7]),
    .a3_d0(t1[3][0]), .a3_d1(t1[3][1]), .a3_d2(t1[3][2]), .a3_d3(t1[3][3]),
    .a3_d4(t1[3][4]), .a3_d5(t1[3][5]), .a3_d6(t1[3][6]), .a3_d7(t1[3][7]),
    .out_v(ov1));

  activation_cache #(.W(W), .DILATION(4)) u4 (
    .clk(clk), .rst(rst), .inp_v(inp_v), .inp_ready(rdy4),
    .inp_d0(inp[0]), .inp_d1(inp[1]), .inp_d2(inp[2]), .inp_d3(inp[3]),
    .inp_d4(inp[4]), .inp_d5(inp[5]), .inp_d6(inp[6]), .inp_d7(inp[7]),
    .a0_d0(t4[0][0]), .a0_d1(t4[0][1]), .a0_d2(t4[0][2]), .a0_d3(t4[0][3]),
    .a0_d4(t4[0][4]), .a0_d5(t4[0][5]), .a0_d6(t4[0][6]), .a0_d7(t4[0][7]),
    .a1_d0(t4[1][0]), .a1_d1(t4[1][1]), .a1_d2(t4[1][2]), .a1_d3(t4[1][3]),
    .a1_d4(t4[1][4]), .a1_d5(t4[1][5]), .a1_d6(t4[1][6]), .a1_d7(t4[1][7]),
    .a2_d0(t4[2][0]), .a2_d1(t4[2][1]), .a2_d2(t4[2][2]), .a2_d3(t4[2][3]),
    .a2_d4(t4[2][4]), .a2_d5(t4[2][5]), .a2_d6(t4[2][6]), .a2_d7(t4[2][7]),
    .a3_d0(t4[3][0]), .a3_d1(t4[3][1]), .a3_d2(t4[3][2]), .a3_d3(t4[3][3]),
    .a3_d4(t4[3][4]), .a3_d5(t4[3][5]), .a3_d6(t4[3][6]), .a3_d7(t4[3][7]),
    .out_v(ov4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Tap k of a dilation-d cache is the sample (3-k)*d positions before the newest.
  function automatic logic [W-1:0] model(int d, int k, int lane);
    int idx = hist.size() - 1 - (3 - k) * d;
    if (idx < 0) return '0;
    return hist[idx][lane];
  endfunction

  function automatic vec_t splat(logic [W-1:0] x);
    vec_t r;
    for (int l = 0; l < 8; l++) r[l] = x;
    return r;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t r;
    for (int l = 0; l < 8; l++) r[l] = W'($urandom);
    return r;
  endfunction

  task automatic chk_taps();
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < 8; l++) begin
        chk($sformatf("d1_a%0d_d%0d", k, l), 32'(t1[k][l]), 32'(model(1, k, l)));
        chk($sformatf("d4_a%0d_d%0d", k, l), 32'(t4[k][l]), 32'(model(4, k, l)));
      end
  endtask

  // Offers one vector on an idle cache and follows it through to its pulse.
  task automatic send(input vec_t v);
    @(negedge clk);
    chk("ready_idle", 32'(rdy1), 1); chk("ready_idle_d4", 32'(rdy4), 1);
    inp_v = 1'b1; inp = v;
    @(posedge clk); #1;
    inp_v = 1'b0; inp = rnd_vec();
    hist.push_back(v);
    chk("ov_k", 32'(ov1), 0); chk("ov_k_d4", 32'(ov4), 0);
    chk("ready_busy", 32'(rdy1), 0);
    @(posedge clk); #1;
    chk("ov_k1", 32'(ov1), 0); chk("ready_busy2", 32'(rdy1), 0);
    @(posedge clk); #1;
    chk("ov_k2", 32'(ov1), 1); chk("ov_k2_d4", 32'(ov4), 1);
    chk_taps();
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    hist.delete();
  endtask

  initial begin
    row_t tbl[5];
    vec_t v, sv;
    bit r;
    tbl[0] = '{in: 16'h1000, e: {16'h1000, 16'h0000, 16'h0000, 16'h0000}};
    tbl[1] = '{in: 16'h2000, e: {16'h2000, 16'h1000, 16'h0000, 16'h0000}};
    tbl[2] = '{in: 16'h3000, e: {16'h3000, 16'h2000, 16'h1000, 16'h0000}};
    tbl[3] = '{in: 16'h4000, e: {16'h4000, 16'h3000, 16'h2000, 16'h1000}};
    tbl[4] = '{in: 16'h5000, e: {16'h5000, 16'h4000, 16'h3000, 16'h2000}};

    // Reset with inp_v held high: nothing may be accepted.
    rst = 1'b1; inp_v = 1'b1; inp = rnd_vec();
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; inp_v = 1'b0;
    chk("rst_ov", 32'(ov1), 0); chk("rst_ov_d4", 32'(ov4), 0);
    chk("rst_ready", 32'(rdy1), 1); chk("rst_ready_d4", 32'(rdy4), 1);
    for (int l = 0; l < 8; l++) chk("rst_a0", 32'(t1[0][l]), 0);
    for (int l = 0; l < 8; l++) chk("rst_a3_d4", 32'(t4[3][l]), 0);
    @(posedge clk); #1;
    chk("rst_no_pulse", 32'(ov1), 0);

    // First sample
    for (int l = 0; l < 8; l++) v[l] = W'((l + 1) * 256);
    send(v);
    for (int l = 0; l < 8; l++) begin
      chk("first_a3", 32'(t1[3][l]), 32'((l + 1) * 256));
      chk("first_a0", 32'(t1[0][l]), 0);
      chk("first_a2", 32'(t1[2][l]), 0);
    end

    // Dilation 1 short stream from the table
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(splat(tbl[i].in));
      for (int k = 0; k < 4; k++)
        for (int l = 0; l < 8; l++)
          chk($sformatf("tbl%0d_a%0d", i, k), 32'(t1[k][l]), 32'(tbl[i].e[k]));
    end

    // Dilation 4 wrap-around
    do_reset();
    for (int n = 1; n <= 30; n++) begin
      send(splat(W'(n)));
      if (n == 12) begin
        chk("d4_n12_a0", 32'(t4[0][3]), 0); chk("d4_n12_a1", 32'(t4[1][3]), 4);
        chk("d4_n12_a2", 32'(t4[2][3]), 8);
      end
      if (n == 13) begin
        chk("d4_n13_a0", 32'(t4[0][0]), 1); chk("d4_n13_a1", 32'(t4[1][0]), 5);
        chk("d4_n13_a2", 32'(t4[2][0]), 9); chk("d4_n13_a3", 32'(t4[3][0]), 13);
      end
      if (n == 30) begin
        chk("d4_n30_a0", 32'(t4[0][7]), 18); chk("d4_n30_a1", 32'(t4[1][7]), 22);
        chk("d4_n30_a2", 32'(t4[2][7]), 26); chk("d4_n30_a3", 32'(t4[3][7]), 30);
      end
    end

    // Signed passthrough
    for (int l = 0; l < 8; l++) sv[l] = (l % 2 == 0) ? 16'hF000 : 16'h8000;
    send(sv);
    for (int l = 0; l < 8; l++) chk("sgn_a3", 32'(t1[3][l]), 32'(sv[l]));
    for (int i = 1; i <= 4; i++) begin
      send(rnd_vec());
      if (i == 1) for (int l = 0; l < 8; l++) chk("sgn_a2_d1", 32'(t1[2][l]), 32'(sv[l]));
      if (i == 4) for (int l = 0; l < 8; l++) chk("sgn_a2_d4", 32'(t4[2][l]), 32'(sv[l]));
    end

    // Backpressure: inp_v held high, data changing every cycle
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      inp_v = 1'b1; inp = rnd_vec();
      r = rdy1;
      chk($sformatf("bp_ready_c%0d", c), 32'(r), 32'(c % 3 == 0));
      if (r) hist.push_back(inp);
      @(posedge clk); #1;
      chk($sformatf("bp_ov_c%0d", c), 32'(ov1), 32'(c % 3 == 2));
      if (c % 3 == 2) chk_taps();
    end
    inp_v = 1'b0;

    // Reset while in READ after 6 samples
    do_reset();
    for (int i = 0; i < 6; i++) send(rnd_vec());
    @(negedge clk); inp_v = 1'b1; inp = rnd_vec();
    @(posedge clk); #1; inp_v = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    hist.delete();
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_ov", 32'(ov1), 0); chk("abort_no_ov_d4", 32'(ov4), 0);
      chk("abort_ready", 32'(rdy1), 1);
      chk("abort_a3", 32'(t1[3][0]), 0);
      @(posedge clk); #1;
    end
    v = rnd_vec();
    send(v);
    for (int l = 0; l < 8; l++) begin
      chk("post_abort_a0", 32'(t1[0][l]), 0); chk("post_abort_a2", 32'(t1[2][l]), 0);
      chk("post_abort_a3", 32'(t1[3][l]), 32'(v[l]));
    end

    // Random stream with random idle gaps
    do_reset();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(rnd_vec());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
